// File: rtl/midi_message_parser_pkg.sv
// Shared definitions for the MIDI message parser.
//   - status-nibble constants for channel voice messages
//   - byte-class boundaries and a classifier function
//   - parser state encoding
//   - held-note counter width and limit
package midi_message_parser_pkg;

  localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [3:0] ST_NOTE_ON    = 4'h9;
  localparam logic [3:0] ST_POLY_AT    = 4'hA;
  localparam logic [3:0] ST_CONTROL    = 4'hB;
  localparam logic [3:0] ST_PROGRAM    = 4'hC;
  localparam logic [3:0] ST_CHAN_AT    = 4'hD;
  localparam logic [3:0] ST_PITCH_BEND = 4'hE;

  // Upper bound (inclusive) of each byte class; real-time is 0xF8-0xFF.
  localparam logic [7:0] DATA_MAX        = 8'h7F;
  localparam logic [7:0] CHAN_STATUS_MAX = 8'hEF;
  localparam logic [7:0] SYS_COMMON_MAX  = 8'hF7;

  localparam int unsigned  HELD_CNT_W   = 5;
  localparam logic [4:0]   HELD_CNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    DATA1       = 2'd1,
    DATA2       = 2'd2
  } parse_state_e;

  typedef enum logic [1:0] {
    BC_DATA     = 2'd0,
    BC_CHAN     = 2'd1,
    BC_SYS_COM  = 2'd2,
    BC_REALTIME = 2'd3
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    if (b <= DATA_MAX)             return BC_DATA;
    else if (b <= CHAN_STATUS_MAX) return BC_CHAN;
    else if (b <= SYS_COMMON_MAX)  return BC_SYS_COM;
    else                           return BC_REALTIME;
  endfunction

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_two_byte(input logic [3:0] msg_type);
    return (msg_type != ST_PROGRAM) && (msg_type != ST_CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_message_parser_byte_strobe.sv
// midi_byte_strobe: turns the UART byteReady level into a one-cycle strobe
// on its low-to-high transition.
//   clock     : sole clock
//   resetN    : asynchronous active-low reset
//   byteReady : level from the UART receiver
//   strobe    : high for the single cycle in which a new byte is consumed
module midi_byte_strobe (
  input  logic clock,
  input  logic resetN,
  input  logic byteReady,
  output logic strobe
);

  logic prev_q, prev_d;
  // armed_q stays low after reset until byteReady has been seen low, so a
  // level already high at reset release is not mistaken for a new byte.
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = byteReady;
    armed_d = armed_q | ~byteReady;
    strobe  = byteReady & ~prev_q & armed_q;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/midi_message_parser.sv
// midi_message_parser: parses a MIDI byte stream (with running status) into
// note-on / note-off events and tracks how many notes are held.
//   clock, resetN   : clock and asynchronous active-low reset
//   byteInput       : received byte, stable while byteReady is high
//   byteReady       : UART level; rising edge marks a new byte
//   eventValid      : one-cycle pulse when the event fields are updated
//   eventNoteOn     : 1 = note-on, 0 = note-off
//   eventChannel    : MIDI channel of the event
//   eventNote       : note number
//   eventVelocity   : velocity
//   gate            : high while the held-note counter is nonzero
// CHANNEL_FILTER=1 restricts events (and gate changes) to LISTEN_CHANNEL.
module midi_message_parser
  import midi_message_parser_pkg::*;
#(
  parameter int         CHANNEL_FILTER = 0,
  parameter logic [3:0] LISTEN_CHANNEL = 4'd0
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] byteInput,
  input  logic       byteReady,
  output logic       eventValid,
  output logic       eventNoteOn,
  output logic [3:0] eventChannel,
  output logic [6:0] eventNote,
  output logic [6:0] eventVelocity,
  output logic       gate
);

  logic strobe;

  midi_byte_strobe u_strobe (
    .clock     (clock),
    .resetN    (resetN),
    .byteReady (byteReady),
    .strobe    (strobe)
  );

  parse_state_e          state_q, state_d;
  logic [3:0]            run_type_q, run_type_d;
  logic [3:0]            run_chan_q, run_chan_d;
  logic [6:0]            data1_q, data1_d;
  logic [HELD_CNT_W-1:0] held_q, held_d;
  logic                  ev_valid_q, ev_valid_d;
  logic                  ev_on_q, ev_on_d;
  logic [3:0]            ev_chan_q, ev_chan_d;
  logic [6:0]            ev_note_q, ev_note_d;
  logic [6:0]            ev_vel_q, ev_vel_d;

  logic is_on, is_off, chan_ok;

  always_comb begin
    state_d    = state_q;
    run_type_d = run_type_q;
    run_chan_d = run_chan_q;
    data1_d    = data1_q;
    held_d     = held_q;
    ev_valid_d = 1'b0;
    ev_on_d    = ev_on_q;
    ev_chan_d  = ev_chan_q;
    ev_note_d  = ev_note_q;
    ev_vel_d   = ev_vel_q;

    // Decode of a completed two-byte message, using the current byte as velocity.
    is_on   = (run_type_q == ST_NOTE_ON) && (byteInput[6:0] != 7'd0);
    is_off  = (run_type_q == ST_NOTE_OFF) ||
              ((run_type_q == ST_NOTE_ON) && (byteInput[6:0] == 7'd0));
    chan_ok = (CHANNEL_FILTER == 0) || (run_chan_q == LISTEN_CHANNEL);

    if (strobe) begin
      unique case (classify_byte(byteInput))
        BC_REALTIME: ; // transparent to the parser
        BC_SYS_COM: begin
          state_d    = WAIT_STATUS;
          run_type_d = 4'd0;
          run_chan_d = 4'd0;
        end
        BC_CHAN: begin
          state_d    = DATA1;
          run_type_d = byteInput[7:4];
          run_chan_d = byteInput[3:0];
        end
        BC_DATA: begin
          unique case (state_q)
            WAIT_STATUS: ; // no running status: discard
            DATA1: begin
              data1_d = byteInput[6:0];
              // One-byte messages complete here and stay in DATA1.
              if (is_two_byte(run_type_q)) state_d = DATA2;
            end
            DATA2: begin
              state_d = DATA1;
              if (chan_ok && (is_on || is_off)) begin
                ev_valid_d = 1'b1;
                ev_on_d    = is_on;
                ev_chan_d  = run_chan_q;
                ev_note_d  = data1_q;
                ev_vel_d   = byteInput[6:0];
                if (is_on && (held_q != HELD_CNT_MAX)) held_d = held_q + 5'd1;
                if (is_off && (held_q != 5'd0))        held_d = held_q - 5'd1;
              end
            end
            default: state_d = WAIT_STATUS;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= WAIT_STATUS;
      run_type_q <= 4'd0;
      run_chan_q <= 4'd0;
      data1_q    <= 7'd0;
      held_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_chan_q  <= 4'd0;
      ev_note_q  <= 7'd0;
      ev_vel_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      run_type_q <= run_type_d;
      run_chan_q <= run_chan_d;
      data1_q    <= data1_d;
      held_q     <= held_d;
      ev_valid_q <= ev_valid_d;
      ev_on_q    <= ev_on_d;
      ev_chan_q  <= ev_chan_d;
      ev_note_q  <= ev_note_d;
      ev_vel_q   <= ev_vel_d;
    end
  end

  assign eventValid    = ev_valid_q;
  assign eventNoteOn   = ev_on_q;
  assign eventChannel  = ev_chan_q;
  assign eventNote     = ev_note_q;
  assign eventVelocity = ev_vel_q;
  // Counter and event register update on the same edge, so gate tracks eventValid.
  assign gate          = (held_q != 5'd0);

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser. A second instance with the channel
// filter enabled (listening on channel 1) shares the same byte stream.
module tb_midi_message_parser;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] byteInput = 8'h00;
  logic       byteReady = 1'b0;

  logic       ev_valid, ev_on, gate;
  logic [3:0] ev_chan;
  logic [6:0] ev_note, ev_vel;

  logic       f_valid, f_on, f_gate;
  logic [3:0] f_chan;
  logic [6:0] f_note, f_vel;

  int errors = 0;
  int checks = 0;

  // Event log: counts pulses and keeps the fields of the most recent one.
  int         ev_cnt = 0;
  logic       last_on;
  logic [3:0] last_chan;
  logic [6:0] last_note, last_vel;
  int         f_cnt = 0;
  logic [3:0] f_last_chan;

  midi_message_parser dut (
    .clock         (clock),
    .resetN        (resetN),
    .byteInput     (byteInput),
    .byteReady     (byteReady),
    .eventValid    (ev_valid),
    .eventNoteOn   (ev_on),
    .eventChannel  (ev_chan),
    .eventNote     (ev_note),
    .eventVelocity (ev_vel),
    .gate          (gate)
  );

  midi_message_parser #(.CHANNEL_FILTER(1), .LISTEN_CHANNEL(4'd1)) dut_f (
    .clock         (clock),
    .resetN        (resetN),
    .byteInput     (byteInput),
    .byteReady     (byteReady),
    .eventValid    (f_valid),
    .eventNoteOn   (f_on),
    .eventChannel  (f_chan),
    .eventNote     (f_note),
    .eventVelocity (f_vel),
    .gate          (f_gate)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ev_valid) begin
      ev_cnt    <= ev_cnt + 1;
      last_on   <= ev_on;
      last_chan <= ev_chan;
      last_note <= ev_note;
      last_vel  <= ev_vel;
    end
    if (f_valid) begin
      f_cnt       <= f_cnt + 1;
      f_last_chan <= f_chan;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    byteInput = b;
    byteReady = 1'b1;
    @(negedge clock);
    byteReady = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    byteReady = 1'b0;
    resetN    = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checks++;
    if ({ev_valid, ev_on, ev_chan, ev_note, ev_vel, gate} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b on=%b ch=%0d note=%0d vel=%0d gate=%b, want all 0",
               ev_valid, ev_on, ev_chan, ev_note, ev_vel, gate);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_note_on();
    int c0;
    do_reset();
    c0 = ev_cnt;
    send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64);
    @(negedge clock);
    checks++;
    if (ev_cnt - c0 !== 1) begin
      errors++; $display("FAIL note_on_count: got %0d, want 1", ev_cnt - c0);
    end
    checks++;
    if ({last_on, last_chan, last_note, last_vel} !== {1'b1, 4'd2, 7'd60, 7'd100}) begin
      errors++;
      $display("FAIL note_on_fields: got on=%b ch=%0d note=%0d vel=%0d, want on=1 ch=2 note=60 vel=100",
               last_on, last_chan, last_note, last_vel);
    end
    checks++;
    if (gate !== 1'b1) begin
      errors++; $display("FAIL note_on_gate: got %b, want 1", gate);
    end
  endtask

  task automatic test_running_status();
    int c0;
    do_reset();
    c0 = ev_cnt;
    send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
    checks++;
    if (ev_cnt - c0 !== 1 || {last_on, last_note, last_vel} !== {1'b1, 7'd64, 7'd80} || gate !== 1'b1) begin
      errors++;
      $display("FAIL rs_first: got n=%0d on=%b note=%0d vel=%0d gate=%b, want n=1 on=1 note=64 vel=80 gate=1",
               ev_cnt - c0, last_on, last_note, last_vel, gate);
    end
    send_byte(8'h40); send_byte(8'h00);
    checks++;
    if (ev_cnt - c0 !== 2 || {last_on, last_note, last_vel} !== {1'b0, 7'd64, 7'd0}) begin
      errors++;
      $display("FAIL rs_second: got n=%0d on=%b note=%0d vel=%0d, want n=2 on=0 note=64 vel=0",
               ev_cnt - c0, last_on, last_note, last_vel);
    end
    checks++;
    if (gate !== 1'b0) begin
      errors++; $display("FAIL rs_gate: got %b, want 0", gate);
    end
  endtask

  task automatic test_realtime();
    int c0;
    do_reset();
    c0 = ev_cnt;
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h7F);
    checks++;
    if (ev_cnt - c0 !== 1 || {last_on, last_chan, last_note, last_vel} !== {1'b1, 4'd0, 7'd60, 7'd127}) begin
      errors++;
      $display("FAIL realtime: got n=%0d on=%b ch=%0d note=%0d vel=%0d, want n=1 on=1 ch=0 note=60 vel=127",
               ev_cnt - c0, last_on, last_chan, last_note, last_vel);
    end
  endtask

  task automatic test_no_event_types();
    int c0;
    do_reset();
    c0 = ev_cnt;
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'hF0); send_byte(8'h3C); send_byte(8'h40);
    send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 0 || gate !== 1'b0) begin
      errors++;
      $display("FAIL prog_syscom: got n=%0d gate=%b, want n=0 gate=0", ev_cnt - c0, gate);
    end
    send_byte(8'hA3); send_byte(8'h3C); send_byte(8'h40);
    send_byte(8'hB3); send_byte(8'h07); send_byte(8'h64);
    send_byte(8'hE3); send_byte(8'h00); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 0) begin
      errors++; $display("FAIL other_types: got n=%0d, want 0", ev_cnt - c0);
    end
    // After a one-byte type, a channel status still restores normal parsing.
    send_byte(8'hC3); send_byte(8'h01); send_byte(8'h93); send_byte(8'h30); send_byte(8'h20);
    checks++;
    if (ev_cnt - c0 !== 1 || last_chan !== 4'd3 || last_note !== 7'd48) begin
      errors++;
      $display("FAIL after_prog: got n=%0d ch=%0d note=%0d, want n=1 ch=3 note=48",
               ev_cnt - c0, last_chan, last_note);
    end
  endtask

  task automatic test_channel_filter();
    int c0, f0;
    do_reset();
    c0 = ev_cnt; f0 = f_cnt;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (f_cnt - f0 !== 0 || f_gate !== 1'b0) begin
      errors++;
      $display("FAIL filter_reject: got n=%0d gate=%b, want n=0 gate=0", f_cnt - f0, f_gate);
    end
    checks++;
    if (ev_cnt - c0 !== 1) begin
      errors++; $display("FAIL nofilter_accept: got n=%0d, want 1", ev_cnt - c0);
    end
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (f_cnt - f0 !== 1 || f_last_chan !== 4'd1 || f_gate !== 1'b1) begin
      errors++;
      $display("FAIL filter_accept: got n=%0d ch=%0d gate=%b, want n=1 ch=1 gate=1",
               f_cnt - f0, f_last_chan, f_gate);
    end
  endtask

  task automatic test_reset_mid_message();
    int c0;
    do_reset();
    c0 = ev_cnt;
    send_byte(8'h90);
    do_reset();
    send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 0) begin
      errors++; $display("FAIL reset_mid: got n=%0d, want 0", ev_cnt - c0);
    end
    // byteReady held high across reset release must not produce a strobe.
    @(negedge clock);
    byteInput = 8'h95;
    byteReady = 1'b1;
    resetN    = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    repeat (3) @(negedge clock);
    byteReady = 1'b0;
    repeat (2) @(negedge clock);
    send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 0) begin
      errors++; $display("FAIL reset_held_ready: got n=%0d, want 0", ev_cnt - c0);
    end
    send_byte(8'h95); send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 1 || last_chan !== 4'd5) begin
      errors++;
      $display("FAIL reset_recover: got n=%0d ch=%0d, want n=1 ch=5", ev_cnt - c0, last_chan);
    end
  endtask

  task automatic test_counter_saturation();
    int c0;
    do_reset();
    c0 = ev_cnt;
    // Note-off with nothing held: event still emitted, counter stays 0.
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (ev_cnt - c0 !== 1 || last_on !== 1'b0 || gate !== 1'b0) begin
      errors++;
      $display("FAIL off_at_zero: got n=%0d on=%b gate=%b, want n=1 on=0 gate=0", ev_cnt - c0, last_on, gate);
    end
    send_byte(8'h90);
    for (int i = 0; i < 33; i++) begin
      send_byte(8'h3C); send_byte(8'h40);
    end
    checks++;
    if (ev_cnt - c0 !== 34 || gate !== 1'b1) begin
      errors++;
      $display("FAIL ons_33: got n=%0d gate=%b, want n=34 gate=1", ev_cnt - c0, gate);
    end
    for (int i = 0; i < 30; i++) begin
      send_byte(8'h3C); send_byte(8'h00);
    end
    checks++;
    if (gate !== 1'b1) begin
      errors++; $display("FAIL sat_high_30_offs: got gate=%b, want 1", gate);
    end
    send_byte(8'h3C); send_byte(8'h00);
    checks++;
    if (gate !== 1'b0) begin
      errors++; $display("FAIL sat_high_31_offs: got gate=%b, want 0", gate);
    end
    send_byte(8'h3C); send_byte(8'h00);
    send_byte(8'h3C); send_byte(8'h40);
    checks++;
    if (gate !== 1'b1 || last_on !== 1'b1) begin
      errors++;
      $display("FAIL sat_low: got gate=%b on=%b, want gate=1 on=1", gate, last_on);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_no_event_types();
    test_channel_filter();
    test_reset_mid_message();
    test_counter_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
